// File: rtl/mcpu_ctrl_pkg.sv
// MCPU control package: state encodings, opcode/funct constants, ALU commands,
// datapath select values and the control-word record shared by the FSM and decoder.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXE    = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [1:0] SRC_A_PC  = 2'd0;
  localparam logic [1:0] SRC_A_REG = 2'd1;

  localparam logic [1:0] SRC_B_IMM_SH = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_REG    = 2'd2;
  localparam logic [1:0] SRC_B_FOUR   = 2'd3;

  localparam logic [1:0] PC_SRC_ALU_REG = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd1;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'd2;

  localparam logic [1:0] REG_DST_RD = 2'd0;
  localparam logic [1:0] REG_DST_RT = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_MDR = 2'd0;
  localparam logic [1:0] M2R_ALU = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       mem_we;
    logic       mem_in;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // True when the opcode (and, for R-type, the funct) is one this control unit executes.
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_R:    ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
      OP_LW, OP_SW, OP_ADDI, OP_XORI,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// MCPU control-word decoder: maps the current state (plus opcode/funct/zero where
// a state needs them) onto every datapath enable and select. Purely combinational.
module mcpu_ctrl_decode
  import mcpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Moore control table; only BRANCH looks at the live zero flag.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_in    = 1'b0;
        ctrl.ir_we     = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU_OUT;
        ctrl.pc_we     = 1'b1;
      end
      S_DECODE: begin
        ctrl.a_we      = 1'b1;
        ctrl.b_we      = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_in = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_in = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      S_R_EXE: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        case (funct)
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = M2R_ALU;
      end
      S_I_EXE: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_I_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALU_REG;
        ctrl.pc_we     = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_SRC_JUMP;
        ctrl.pc_we  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.pc_we      = 1'b1;
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mcpu_control_fsm.sv
// MCPU multi-cycle control unit: FETCH/DECODE/EXE/MEM/WB sequencer, retired
// instruction counter and illegal-instruction handling.
// Build option: define MCPU_ILLEGAL_TRAP_EN to trap on illegal opcode/funct
// (sticky illegal flag, halt in TRAP); otherwise illegal instructions retire as NOPs.
module mcpu_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic             a_we,
  output logic             b_we,
  output logic             mem_we,
  output logic             mem_in,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);
  import mcpu_ctrl_pkg::*;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  ctrl_t            ctrl;

  // State register; reset parks the machine in FETCH so the first edge fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_nxt;
  end

  // Next-state sequencing; DECODE dispatches on the latched opcode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (!is_legal(opcode, funct)) begin
`ifdef MCPU_ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
            OP_R:             state_nxt = S_R_EXE;
            OP_ADDI, OP_XORI: state_nxt = S_I_EXE;
            OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
            OP_J:             state_nxt = S_JUMP;
            OP_JAL:           state_nxt = S_JAL;
            default:          state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = S_MEM_WB;
      S_R_EXE:    state_nxt = S_R_WB;
      S_I_EXE:    state_nxt = S_I_WB;
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL: state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Any return to FETCH from another state is the end of an instruction.
  assign retire = (state_nxt == S_FETCH) && (state_q != S_FETCH);

  // Retired-instruction counter, wrapping silently at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

`ifdef MCPU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal flag, set on entry into TRAP and held until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    illegal_q <= 1'b0;
    else if (state_nxt == S_TRAP)  illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  mcpu_ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  // Write enables are squashed while reset is held so an aborted instruction cannot commit.
  assign pc_we      = ctrl.pc_we  & reset;
  assign ir_we      = ctrl.ir_we  & reset;
  assign a_we       = ctrl.a_we   & reset;
  assign b_we       = ctrl.b_we   & reset;
  assign mem_we     = ctrl.mem_we & reset;
  assign reg_we     = ctrl.reg_we & reset;
  assign mem_in     = ctrl.mem_in;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Self-checking bench for mcpu_control_fsm: a table of instructions drives a
// scoreboard of per-cycle expected control words, plus hand-written sequences
// for reset abort and illegal-instruction handling (MCPU_ILLEGAL_TRAP_EN aware).
module tb_mcpu_control_fsm;
  import mcpu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_we, ir_we, a_we, b_we, mem_we, mem_in, reg_we;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        illegal;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            z;
    logic [2:0]      n;
    logic [4:0][3:0] path;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] cw;
    logic [31:0] ir;
    string       tag;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          total_checks;
  int          passed_checks;
  logic [31:0] retired;

  mcpu_control_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .a_we       (a_we),
    .b_we       (b_we),
    .mem_we     (mem_we),
    .mem_in     (mem_in),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state),
    .instret    (instret),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed_checks++;
  endtask

  // Control word the datapath should see in a given state, written from the state table.
  function automatic logic [19:0] exp_cw(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] fn, input logic z);
    logic       p_we, i_we, aw, bw, m_we, m_in, r_we;
    logic [1:0] rdst, m2r, sa, sbs, psrc;
    logic [2:0] aop;
    {p_we, i_we, aw, bw, m_we, m_in, r_we} = '0;
    {rdst, m2r, sa, sbs, psrc} = '0;
    aop = 3'd0;
    case (st)
      S_FETCH:    begin i_we = 1; sbs = 2'd3; psrc = 2'd2; p_we = 1; end
      S_DECODE:   begin aw = 1; bw = 1; end
      S_MEM_ADDR: begin sa = 2'd1; sbs = 2'd1; end
      S_MEM_RD:   m_in = 1;
      S_MEM_WB:   begin r_we = 1; rdst = 2'd1; end
      S_MEM_WR:   begin m_in = 1; m_we = 1; end
      S_R_EXE:    begin
        sa = 2'd1; sbs = 2'd2;
        aop = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
      end
      S_R_WB:     begin r_we = 1; m2r = 2'd1; end
      S_I_EXE:    begin sa = 2'd1; sbs = 2'd1; aop = (op == 6'h0E) ? 3'd2 : 3'd0; end
      S_I_WB:     begin r_we = 1; rdst = 2'd1; m2r = 2'd1; end
      S_BRANCH:   begin sa = 2'd1; sbs = 2'd2; aop = 3'd1; p_we = (op == 6'h05) ? ~z : z; end
      S_JUMP:     begin psrc = 2'd1; p_we = 1; end
      S_JAL:      begin psrc = 2'd1; p_we = 1; r_we = 1; rdst = 2'd2; m2r = 2'd2; end
      default:    ;
    endcase
    return {p_we, i_we, aw, bw, m_we, m_in, r_we, rdst, m2r, sa, sbs, aop, psrc};
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic [2:0] n, input logic [3:0] p0, input logic [3:0] p1,
                              input logic [3:0] p2, input logic [3:0] p3, input logic [3:0] p4);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.n = n;
    v.path[0] = p0; v.path[1] = p1; v.path[2] = p2; v.path[3] = p3; v.path[4] = p4;
    return v;
  endfunction

  // Drive one instruction from a FETCH boundary, queue its per-cycle expectations, run it out.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    for (int c = 0; c < int'(v.n); c++) begin
      e.st  = v.path[c];
      e.cw  = exp_cw(v.path[c], v.op, v.fn, v.z);
      e.ir  = retired;
      e.tag = $sformatf("op%02h_fn%02h_z%0d_c%0d", v.op, v.fn, v.z, c);
      sb.push_back(e);
    end
    retired = retired + 32'd1;
    repeat (int'(v.n)) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compares one queued expectation each falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.tag, "_state"}, 32'(state), 32'(e.st));
      checkOutput({e.tag, "_ctrl"},
                  32'({pc_we, ir_we, a_we, b_we, mem_we, mem_in, reg_we, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, alu_op, pc_src}), 32'(e.cw));
      checkOutput({e.tag, "_instret"}, instret, e.ir);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    retired       = 32'd0;
    reset  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;

    vecs.push_back(mk(6'h23, 6'h00, 1'b0, 3'd5, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB));
    vecs.push_back(mk(6'h2B, 6'h00, 1'b0, 3'd4, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_FETCH));
    vecs.push_back(mk(6'h00, 6'h20, 1'b0, 3'd4, S_FETCH, S_DECODE, S_R_EXE, S_R_WB, S_FETCH));
    vecs.push_back(mk(6'h00, 6'h22, 1'b1, 3'd4, S_FETCH, S_DECODE, S_R_EXE, S_R_WB, S_FETCH));
    vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 3'd4, S_FETCH, S_DECODE, S_R_EXE, S_R_WB, S_FETCH));
    vecs.push_back(mk(6'h08, 6'h11, 1'b0, 3'd4, S_FETCH, S_DECODE, S_I_EXE, S_I_WB, S_FETCH));
    vecs.push_back(mk(6'h0E, 6'h00, 1'b1, 3'd4, S_FETCH, S_DECODE, S_I_EXE, S_I_WB, S_FETCH));
    vecs.push_back(mk(6'h04, 6'h00, 1'b1, 3'd3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h04, 6'h00, 1'b0, 3'd3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h05, 6'h00, 1'b1, 3'd3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h05, 6'h00, 1'b0, 3'd3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h02, 6'h00, 1'b0, 3'd3, S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h03, 6'h00, 1'b0, 3'd3, S_FETCH, S_DECODE, S_JAL, S_FETCH, S_FETCH));
`ifndef MCPU_ILLEGAL_TRAP_EN
    vecs.push_back(mk(6'h3F, 6'h00, 1'b0, 3'd2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH));
    vecs.push_back(mk(6'h00, 6'h3F, 1'b0, 3'd2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH));
`endif

    // Reset held: parked in FETCH with every write enable squashed.
    #12;
    checkOutput("rst_state",   32'(state), 32'(S_FETCH));
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_we",      32'({pc_we, ir_we, a_we, b_we, mem_we, reg_we}), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset falls mid-MEM_WR: mem_we must drop at once and the store is not retired.
    opcode = 6'h2B;
    funct  = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pre_state",  32'(state), 32'(S_MEM_WR));
    checkOutput("abort_pre_mem_we", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_mem_we",  32'(mem_we), 32'd0);
    checkOutput("abort_state",   32'(state), 32'(S_FETCH));
    checkOutput("abort_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    retired = 32'd0;
    checkOutput("release_state",   32'(state), 32'(S_FETCH));
    checkOutput("release_instret", instret, 32'd0);

    // LW straight out of reset retires once.
    applyStimulus(vecs[0]);
    checkOutput("lw_after_rst_instret", instret, 32'd1);

`ifdef MCPU_ILLEGAL_TRAP_EN
    // Illegal opcode traps: normal FETCH/DECODE, then TRAP with no writes for good.
    begin
      exp_t e;
      opcode = 6'h3F;
      funct  = 6'h00;
      zero   = 1'b0;
      for (int c = 0; c < 2; c++) begin
        e.st  = (c == 0) ? S_FETCH : S_DECODE;
        e.cw  = exp_cw(e.st, 6'h3F, 6'h00, 1'b0);
        e.ir  = retired;
        e.tag = $sformatf("trap_c%0d", c);
        sb.push_back(e);
      end
      repeat (2) @(posedge clk);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        checkOutput($sformatf("trap_state_%0d", c), 32'(state), 32'(S_TRAP));
        checkOutput($sformatf("trap_we_%0d", c),
                    32'({pc_we, ir_we, a_we, b_we, mem_we, reg_we}), 32'd0);
        checkOutput($sformatf("trap_illegal_%0d", c), 32'(illegal), 32'd1);
      end
      checkOutput("trap_instret", instret, retired);
    end
`else
    checkOutput("nop_illegal_flag", 32'(illegal), 32'd0);
    checkOutput("final_state", 32'(state), 32'(S_FETCH));
`endif

    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
